// File: rtl/risc_mem_pkg.sv
// Shared types and constants for the load/store data path.
// Contents:
//   RV_XLEN       data/address width of the RV32 core
//   BE_W          byte-enable width (one enable per byte lane)
//   mem_funct3_e  load/store funct3 width codes (loads and stores share encodings)
//   dmr_state_e   responder FSM states
//   funct3_legal  true when a funct3 code is a defined load or store
package risc_mem_pkg;

  localparam int RV_XLEN = 32;
  localparam int BE_W    = RV_XLEN / 8;

  // LB/SB, LH/SH and LW/SW use the same code, so one name covers each pair.
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } mem_funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmr_state_e;

  // Unsigned widths exist only for loads.
  function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between the core and a word-organised RAM.
// Ports:
//   write          1 = store, 0 = load
//   addr_lo        byte offset within the word (addr[1:0])
//   funct3         RV32 load/store width code
//   wdata          store data, right-justified
//   ram_word       current RAM word at the addressed location
//   byte_en        store byte enables
//   wdata_aligned  store data replicated onto every lane it may land in
//   rdata_ext      load data shifted down and sign/zero extended
//   misalign       access not naturally aligned for its width
//   illegal        funct3 is not a defined load/store for this direction
module mem_lane_align
  import risc_mem_pkg::*;
(
  input  logic               write,
  input  logic [1:0]         addr_lo,
  input  logic [2:0]         funct3,
  input  logic [RV_XLEN-1:0] wdata,
  input  logic [RV_XLEN-1:0] ram_word,
  output logic [BE_W-1:0]    byte_en,
  output logic [RV_XLEN-1:0] wdata_aligned,
  output logic [RV_XLEN-1:0] rdata_ext,
  output logic               misalign,
  output logic               illegal
);

  logic [RV_XLEN-1:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    byte_en       = '0;
    wdata_aligned = '0;
    rdata_ext     = '0;
    misalign      = 1'b0;
    illegal       = !funct3_legal(write, funct3);
    // Bring the addressed byte/half down to bit 0 for load extension.
    shifted       = ram_word >> {addr_lo, 3'b000};

    case (funct3)
      F3_B, F3_BU: begin
        byte_en       = BE_W'(1) << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
        rdata_ext     = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'b0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        misalign      = addr_lo[0];
        byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_aligned = {2{wdata[15:0]}};
        rdata_ext     = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'b0, shifted[15:0]};
      end
      F3_W: begin
        misalign      = (addr_lo != 2'b00);
        byte_en       = '1;
        wdata_aligned = wdata;
        rdata_ext     = ram_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's load/store data path with configurable wait states.
// One request is accepted in IDLE, WAIT_CYCLES cycles elapse, then the response
// is held in RESP until consumed. The RAM is written / read on the edge entering RESP.
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   req_valid / req_ready     request handshake (req_ready high only in IDLE)
//   req_write                 1 = store, 0 = load
//   req_addr                  byte address
//   req_funct3                RV32 load/store funct3
//   req_wdata                 store data, right-justified
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata                 extended load data; 0 for stores and errors
//   rsp_err                   misaligned, illegal funct3 or out-of-range access
module data_mem_responder
  import risc_mem_pkg::*;
#(
  parameter int    XLEN        = RV_XLEN,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmr_state_e       state;
  logic [CNT_W-1:0] wait_cnt;

  logic             lat_write;
  logic [XLEN-1:0]  lat_addr;
  logic [2:0]       lat_funct3;
  logic [XLEN-1:0]  lat_wdata;

  logic             cur_write;
  logic [XLEN-1:0]  cur_addr;
  logic [2:0]       cur_funct3;
  logic [XLEN-1:0]  cur_wdata;

  logic             accept;
  logic             enter_resp;
  logic             commit;
  logic             out_of_range;
  logic             misalign;
  logic             illegal;
  logic             err;
  logic             ram_we;
  logic [IDX_W-1:0] idx;
  logic [XLEN-1:0]  ram_word;
  logic [BE_W-1:0]  byte_en;
  logic [XLEN-1:0]  wdata_aligned;
  logic [XLEN-1:0]  rdata_ext;

  logic [XLEN-1:0]  ram [DEPTH_WORDS];

  assign accept     = req_valid && req_ready;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (wait_cnt == CNT_LAST));
  // A reset on the commit edge wins: the transaction is aborted, not committed.
  assign commit     = enter_resp && !rst;

  // With no wait states the commit edge is the accept edge, so the live request
  // must be used before it has been latched.
  assign cur_write  = (state == IDLE) ? req_write  : lat_write;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

  assign out_of_range = (cur_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS));
  assign idx          = cur_addr[2 +: IDX_W];
  assign ram_word     = ram[idx];
  assign err          = misalign || illegal || out_of_range;
  assign ram_we       = commit && cur_write && !err;

  mem_lane_align u_lane_align (
    .write         (cur_write),
    .addr_lo       (cur_addr[1:0]),
    .funct3        (cur_funct3),
    .wdata         (cur_wdata),
    .ram_word      (ram_word),
    .byte_en       (byte_en),
    .wdata_aligned (wdata_aligned),
    .rdata_ext     (rdata_ext),
    .misalign      (misalign),
    .illegal       (illegal)
  );

  // NOTE: the RAM array has no reset; clearing it would forbid RAM inference and
  // a committed store must survive a later reset anyway.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (ram_we && byte_en[b]) ram[idx][8*b +: 8] <= wdata_aligned[8*b +: 8];
    end
  end

  // Request fields only matter from accept onward, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= req_write;
      lat_addr   <= req_addr;
      lat_funct3 <= req_funct3;
      lat_wdata  <= req_wdata;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            wait_cnt  <= '0;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == CNT_LAST) state <= RESP;
          else                      wait_cnt <= wait_cnt + 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || cur_write) ? '0 : rdata_ext;
      end
    end
  end

endmodule
